// File: rtl/matmul_seq_engine_pkg.sv
// Shared definitions for the sequential matrix-multiply engine: default sizes,
// operation-register word map, opcode values and the FSM state encoding.
package matmul_seq_engine_pkg;

    localparam int DEF_MEM_SIZE = 4;
    localparam int SEQ_BITS     = $clog2(DEF_MEM_SIZE + 1);

    localparam int OPREG_WORDS  = 6;
    localparam int OPREG_W      = 32;

    localparam int OPREG_OP     = 0;
    localparam int OPREG_WA     = 1;
    localparam int OPREG_HA     = 2;
    localparam int OPREG_WB     = 3;
    localparam int OPREG_HB     = 4;
    localparam int OPREG_GO     = 5;

    localparam logic [31:0] OP_MATMUL = 32'h1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_MAC    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // A dimension word only fits the counters when nothing is set above idx_w;
    // anything larger is necessarily beyond the matrix size.
    function automatic logic dim_fits(input logic [31:0] word, input int idx_w);
        return (word >> idx_w) == 32'd0;
    endfunction

endpackage

// File: rtl/matmul_seq_engine_if.sv
// Bus between the Wishbone accelerator top (master) and the compute engine
// (slave): start level, operation words, operand matrices, result and status.
interface matmul_seq_engine_if
    import matmul_seq_engine_pkg::*;
#(
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    parameter int DATA_W   = 32
);

    logic                                  enable;
    logic [OPREG_WORDS*OPREG_W-1:0]        operation_reg_port;
    logic [DATA_W*MEM_SIZE*MEM_SIZE-1:0]   matrixA_in_port;
    logic [DATA_W*MEM_SIZE*MEM_SIZE-1:0]   matrixB_in_port;
    logic [DATA_W*MEM_SIZE*MEM_SIZE-1:0]   matrixC_out_port;
    logic                                  done;
    logic                                  error;

    modport master (
        output enable,
        output operation_reg_port,
        output matrixA_in_port,
        output matrixB_in_port,
        input  matrixC_out_port,
        input  done,
        input  error
    );

    modport slave (
        input  enable,
        input  operation_reg_port,
        input  matrixA_in_port,
        input  matrixB_in_port,
        output matrixC_out_port,
        output done,
        output error
    );

endinterface

// File: rtl/matmul_seq_engine_mac_unit.sv
// Single multiply-accumulate step: acc + a*b, wrapping modulo 2^DATA_W.
// Kept separate so a pipelined multiplier can be dropped in later.
module matmul_seq_engine_mac_unit #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic [DATA_W-1:0] sum
);

    assign sum = acc + operand_a * operand_b;

endmodule

// File: rtl/matmul_seq_engine.sv
// Sequential matrix-multiply engine: one multiply-accumulate per cycle,
// i/j outer loops and k inner loop, result held in a registered C matrix.
module matmul_seq_engine
    import matmul_seq_engine_pkg::*;
#(
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    parameter int DATA_W   = 32,
    parameter int IDX_W    = $clog2(MEM_SIZE + 1)
) (
    input  logic                clk,
    input  logic                reset,
    matmul_seq_engine_if.slave  bus
);

    localparam int ELEM_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE * MEM_SIZE) : 1;
    localparam logic [IDX_W-1:0] N_DIM = IDX_W'(MEM_SIZE);
    localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

    typedef logic [MEM_SIZE*MEM_SIZE-1:0][DATA_W-1:0] mat_t;

    mat_t                              a_mat;
    mat_t                              b_mat;
    mat_t                              c_mat;
    logic [OPREG_WORDS-1:0][OPREG_W-1:0] op_words;

    state_t                            state;
    logic [31:0]                       opcode_q;
    logic [IDX_W-1:0]                  k_dim;
    logic [IDX_W-1:0]                  m_dim;
    logic [IDX_W-1:0]                  p_dim;
    logic [IDX_W-1:0]                  kb_dim;
    logic                              dims_fit;

    logic [IDX_W-1:0]                  i_cnt;
    logic [IDX_W-1:0]                  j_cnt;
    logic [IDX_W-1:0]                  k_cnt;
    logic [DATA_W-1:0]                 acc;
    logic [DATA_W-1:0]                 mac_sum;
    logic [ELEM_W-1:0]                 a_idx;
    logic [ELEM_W-1:0]                 b_idx;
    logic [ELEM_W-1:0]                 c_idx;
    logic                              start_valid;
    logic                              done_q;
    logic                              error_q;
    logic                              unused_go;

    assign op_words = bus.operation_reg_port;
    assign a_mat    = bus.matrixA_in_port;
    assign b_mat    = bus.matrixB_in_port;

    assign bus.matrixC_out_port = c_mat;
    assign bus.done             = done_q;
    assign bus.error            = error_q;

    // The go word is only meaningful to the top; the engine starts on enable.
    assign unused_go = ^op_words[OPREG_GO];

    assign a_idx = ELEM_W'(int'(i_cnt) * MEM_SIZE + int'(k_cnt));
    assign b_idx = ELEM_W'(int'(k_cnt) * MEM_SIZE + int'(j_cnt));
    assign c_idx = ELEM_W'(int'(i_cnt) * MEM_SIZE + int'(j_cnt));

    assign start_valid = (opcode_q == OP_MATMUL) && dims_fit &&
                         (k_dim == kb_dim) &&
                         (k_dim != '0) && (k_dim <= N_DIM) &&
                         (m_dim != '0) && (m_dim <= N_DIM) &&
                         (p_dim != '0) && (p_dim <= N_DIM);

    matmul_seq_engine_mac_unit #(
        .DATA_W(DATA_W)
    ) u_mac (
        .acc      (acc),
        .operand_a(a_mat[a_idx]),
        .operand_b(b_mat[b_idx]),
        .sum      (mac_sum)
    );

    // Control FSM: latch the operation, validate it, step the MAC loops and
    // hold the result until the top releases enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            done_q   <= 1'b1;
            error_q  <= 1'b0;
            c_mat    <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            acc      <= '0;
            opcode_q <= '0;
            k_dim    <= '0;
            m_dim    <= '0;
            p_dim    <= '0;
            kb_dim   <= '0;
            dims_fit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.enable) begin
                        opcode_q <= op_words[OPREG_OP];
                        k_dim    <= IDX_W'(op_words[OPREG_WA]);
                        m_dim    <= IDX_W'(op_words[OPREG_HA]);
                        p_dim    <= IDX_W'(op_words[OPREG_WB]);
                        kb_dim   <= IDX_W'(op_words[OPREG_HB]);
                        dims_fit <= dim_fits(op_words[OPREG_WA], IDX_W) &&
                                    dim_fits(op_words[OPREG_HA], IDX_W) &&
                                    dim_fits(op_words[OPREG_WB], IDX_W) &&
                                    dim_fits(op_words[OPREG_HB], IDX_W);
                        done_q   <= 1'b0;
                        error_q  <= 1'b0;
                        state    <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    c_mat <= '0;
                    i_cnt <= '0;
                    j_cnt <= '0;
                    k_cnt <= '0;
                    acc   <= '0;
                    if (!bus.enable) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (!start_valid) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state   <= ST_FINISH;
                    end else begin
                        state <= ST_MAC;
                    end
                end

                ST_MAC: begin
                    if (!bus.enable) begin
                        c_mat   <= '0;
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        k_cnt   <= '0;
                        acc     <= '0;
                        done_q  <= 1'b1;
                        error_q <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (k_cnt != k_dim - ONE) begin
                        acc   <= mac_sum;
                        k_cnt <= k_cnt + ONE;
                    end else begin
                        c_mat[c_idx] <= mac_sum;
                        acc          <= '0;
                        k_cnt        <= '0;
                        if (j_cnt == p_dim - ONE) begin
                            j_cnt <= '0;
                            if (i_cnt == m_dim - ONE) begin
                                done_q <= 1'b1;
                                state  <= ST_FINISH;
                            end else begin
                                i_cnt <= i_cnt + ONE;
                            end
                        end else begin
                            j_cnt <= j_cnt + ONE;
                        end
                    end
                end

                ST_FINISH: begin
                    if (!bus.enable) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
